reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Architectural general-purpose register file with an integrated write-pending scoreboard. It sits at the consumer end of the writeback stage: each cycle it accepts the write request (we, waddr, wdata) leaving the MEM/WB pipeline register. It serves two combinational read ports to decode, with same-cycle writeback bypass. A per-register pending counter, incremented at issue and decremented at writeback, lets decode raise a stall while an operand is still in flight.

## Interface
- DATA_W, default 32: register width.
- CNT_W, default 2: pending-counter width; max in-flight writes per register = 2^CNT_W - 1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wb_we  in  1  writeback write enable.
- wb_waddr  in  5  writeback destination register.
- wb_wdata  in  DATA_W  writeback data.
- raddr1, raddr2  in  5  read addresses.
- ren1, ren2  in  1  read port actually used by the instruction in decode.
- rdata1, rdata2  out  DATA_W  read data, combinational.
- rbusy1, rbusy2  out  1  operand has an outstanding write, combinational.
- iss_valid  in  1  instruction with a register destination issues this cycle.
- iss_waddr  in  5  its destination.
- iss_ready  out  1  issue may be accepted, combinational.
- flush  in  1  pipeline flush; discard all pending state.
- stall_req  out  1  (ren1 & rbusy1) | (ren2 & rbusy2).

## Operation
- Storage: 31 registers of DATA_W (r1..r31). r0 reads 0, ignores writes, is never pending, and never busy.
- Write: if wb_we and wb_waddr != 0, then reg[wb_waddr] <= wb_wdata at the clock edge.
- Read: rdata_n = 0 if raddr_n == 0. Otherwise it is wb_wdata if wb_we and wb_waddr == raddr_n (bypass). Otherwise it is reg[raddr_n].
- Pending counter cnt[r], CNT_W bits, r = 1..31. Per edge, with inc = iss_valid & iss_ready & iss_waddr == r and dec = wb_we & wb_waddr == r & cnt[r] != 0:
  - inc & !dec: cnt + 1.
  - dec & !inc: cnt - 1.
  - both or neither: unchanged.
- Underflow: a writeback to a register with cnt == 0 still writes data; the counter stays 0.
- iss_ready = 0 only when iss_waddr != 0 and cnt[iss_waddr] is all-ones and no dec hits that register this cycle. An issue to r0 is always ready and has no counter effect.
- rbusy_n = 1 iff raddr_n != 0 and eff_cnt[raddr_n] != 0. eff_cnt is the counter minus 1 when a dec hits the register this cycle, with the bypass supplying the data.
- rbusy does not include the same-cycle issue (the instruction in decode is the issuer).
- flush: all counters <= 0 at the edge. Register data and the same-cycle writeback are unaffected. Issue in the flush cycle is discarded.
- Priority: rst > flush > normal update.

## Timing
- Reset: all registers 0 and all counters 0. From the first cycle after reset: rdata = 0 (absent bypass), rbusy = 0, stall_req = 0, iss_ready = 1.
- Read latency 0 (combinational). Write visible through storage on the cycle after the edge; visible in the same cycle through the bypass.
- Counter effect of an issue is visible on rbusy in the next cycle.
- No handshake on writeback; wb_we is trusted. The upstream stage presents we = 0 during bubbles.
- rst asserted mid-operation clears everything on that edge regardless of other inputs.

## Test plan
- Reset then read: rst 1 cycle; raddr1 = 5, raddr2 = 0 -> rdata1 = 0, rdata2 = 0, rbusy = 0, iss_ready = 1.
- Write/bypass: wb_we = 1, waddr = 7, wdata = 0xDEADBEEF with raddr1 = 7 -> rdata1 = 0xDEADBEEF in the same cycle. Next cycle, wb_we = 0 -> still 0xDEADBEEF. A write to r0 with 0x1234 -> read r0 = 0.
- Scoreboard: issue r3 -> next cycle rbusy1 = 1 for raddr1 = 3, and with ren1 = 1 stall_req = 1. Writeback r3 = 0x55 -> same cycle rbusy1 = 0, rdata1 = 0x55, stall_req = 0.
- Saturation: three issues to r9 (CNT_W = 2) -> iss_ready = 0 for iss_waddr = 9. Apply a writeback to r9 in the same cycle as the fourth issue -> iss_ready = 1 and the counter stays 3.
- Simultaneous inc/dec and underflow: cnt[4] = 1; issue r4 and writeback r4 together -> cnt stays 1 and rbusy stays 1. A writeback to r10 with cnt 0 -> data written, rbusy for r10 = 0.
- Flush and reset mid-operation: pend r2 and r6; assert flush -> next cycle both not busy, data intact. Pend r2 again; assert rst -> all registers read 0 and nothing is busy.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Bus bundle between decode/writeback and the register file scoreboard.
// Carries writeback, two read ports, issue tracking, flush and stall.
interface reg_file_sb_if #(
    parameter int DATA_W = 32
);
    logic              wb_we;
    logic [4:0]        wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic [4:0]        raddr1;
    logic [4:0]        raddr2;
    logic              ren1;
    logic              ren2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rbusy1;
    logic              rbusy2;
    logic              iss_valid;
    logic [4:0]        iss_waddr;
    logic              iss_ready;
    logic              flush;
    logic              stall_req;

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output raddr1, raddr2, ren1, ren2,
        output iss_valid, iss_waddr, flush,
        input  rdata1, rdata2, rbusy1, rbusy2,
        input  iss_ready, stall_req
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  raddr1, raddr2, ren1, ren2,
        input  iss_valid, iss_waddr, flush,
        output rdata1, rdata2, rbusy1, rbusy2,
        output iss_ready, stall_req
    );
endinterface

// File: rtl/reg_file_sb.sv
// GPR file (r1..r31, r0 hardwired zero) with write bypass and a
// per-register pending-write counter used to stall decode on hazards.
// Ports: clk, rst (sync, active-high), bus (reg_file_sb_if.slave).
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input logic         clk,
    input logic         rst,
    reg_file_sb_if.slave bus
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_ONE = cnt_t'(1);

    logic [DATA_W-1:0] regs_q [1:31];
    logic [DATA_W-1:0] regs_d [1:31];
    cnt_t              cnt_q  [1:31];
    cnt_t              cnt_d  [1:31];

    logic [31:1]       dec_vec;
    logic              iss_ready;
    logic [4:0]        raddr [2];
    logic              ren   [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;
    assign ren[0]   = bus.ren1;
    assign ren[1]   = bus.ren2;

    // A writeback only retires a pending write if one is outstanding;
    // otherwise the counter would wrap.
    always_comb begin
        dec_vec = '0;
        for (int r = 1; r < 32; r++) begin
            dec_vec[r] = bus.wb_we
                       && (bus.wb_waddr == 5'(r))
                       && (cnt_q[r] != '0);
        end
    end

    // A full counter can still take an issue if a writeback frees a
    // slot in the same cycle.
    always_comb begin
        iss_ready = 1'b1;
        if (bus.iss_waddr != 5'd0) begin
            if (cnt_q[bus.iss_waddr] == CNT_MAX
                && !dec_vec[bus.iss_waddr]) begin
                iss_ready = 1'b0;
            end
        end
    end

    // Read ports: bypass the in-flight writeback, and treat its retiring
    // write as no longer pending.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (raddr[p] != 5'd0) begin
                if (bus.wb_we && bus.wb_waddr == raddr[p]) begin
                    rdata[p] = bus.wb_wdata;
                end else begin
                    rdata[p] = regs_q[raddr[p]];
                end
                rbusy[p] = (cnt_q[raddr[p]] != '0)
                         && !(dec_vec[raddr[p]]
                              && cnt_q[raddr[p]] == CNT_ONE);
            end
        end
    end

    assign bus.rdata1    = rdata[0];
    assign bus.rdata2    = rdata[1];
    assign bus.rbusy1    = rbusy[0];
    assign bus.rbusy2    = rbusy[1];
    assign bus.iss_ready = iss_ready;
    assign bus.stall_req = (ren[0] & rbusy[0]) | (ren[1] & rbusy[1]);

    // Next state: data write plus counter inc/dec. Flush clears the
    // counters and drops the same-cycle issue, but not the data write.
    always_comb begin
        logic inc;
        inc    = 1'b0;
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (bus.wb_we && bus.wb_waddr != 5'd0) begin
            regs_d[bus.wb_waddr] = bus.wb_wdata;
        end
        for (int r = 1; r < 32; r++) begin
            inc = bus.iss_valid && iss_ready
                && (bus.iss_waddr == 5'(r));
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, r0, scoreboard, saturation,
// simultaneous inc/dec, underflow, flush and mid-run reset.
module tb_reg_file_sb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_file_sb_if #(.DATA_W(32)) bus ();

    reg_file_sb #(
        .DATA_W(32),
        .CNT_W (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_we     = 1'b0;
        bus.iss_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        bus.wb_waddr  = '0;
        bus.wb_wdata  = '0;
        bus.raddr1    = '0;
        bus.raddr2    = '0;
        bus.ren1      = 1'b0;
        bus.ren2      = 1'b0;
        bus.iss_waddr = '0;
        step();
        rst = 1'b0;

        // reset state
        bus.raddr1 = 5'd5; bus.raddr2 = 5'd0;
        bus.ren1 = 1'b1; bus.ren2 = 1'b1;
        bus.iss_waddr = 5'd5;
        #1;
        chk("rst_rdata1", bus.rdata1, 32'h0);
        chk("rst_rdata2", bus.rdata2, 32'h0);
        chk("rst_rbusy1", 32'(bus.rbusy1), 32'h0);
        chk("rst_rbusy2", 32'(bus.rbusy2), 32'h0);
        chk("rst_ready", 32'(bus.iss_ready), 32'h1);
        chk("rst_stall", 32'(bus.stall_req), 32'h0);

        // write with bypass, then via storage
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd7;
        bus.wb_wdata = 32'hDEADBEEF; bus.raddr1 = 5'd7;
        #1;
        chk("byp_r7", bus.rdata1, 32'hDEADBEEF);
        step();
        idle();
        #1;
        chk("sto_r7", bus.rdata1, 32'hDEADBEEF);

        // r0 ignores writes
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd0;
        bus.wb_wdata = 32'h1234; bus.raddr2 = 5'd0;
        #1;
        chk("r0_byp", bus.rdata2, 32'h0);
        step();
        idle();
        #1;
        chk("r0_sto", bus.rdata2, 32'h0);

        // scoreboard hazard on r3
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd3;
        step();
        idle();
        bus.raddr1 = 5'd3; bus.ren1 = 1'b1; bus.ren2 = 1'b0;
        #1;
        chk("r3_busy", 32'(bus.rbusy1), 32'h1);
        chk("r3_stall", 32'(bus.stall_req), 32'h1);
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'h55;
        #1;
        chk("r3_wb_busy", 32'(bus.rbusy1), 32'h0);
        chk("r3_wb_data", bus.rdata1, 32'h55);
        chk("r3_wb_stall", 32'(bus.stall_req), 32'h0);
        step();
        idle();
        #1;
        chk("r3_after", 32'(bus.rbusy1), 32'h0);
        chk("r3_after_d", bus.rdata1, 32'h55);

        // saturation on r9
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd9;
        step(); step(); step();
        bus.raddr2 = 5'd9;
        #1;
        chk("r9_full", 32'(bus.iss_ready), 32'h0);
        chk("r9_busy", 32'(bus.rbusy2), 32'h1);
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd9; bus.wb_wdata = 32'h99;
        #1;
        chk("r9_free", 32'(bus.iss_ready), 32'h1);
        step();
        idle();
        #1;
        chk("r9_still3", 32'(bus.iss_ready), 32'h0);
        bus.wb_we = 1'b1;
        step(); step();
        #1;
        chk("r9_last", 32'(bus.rbusy2), 32'h0);
        step();
        idle();
        #1;
        chk("r9_ready", 32'(bus.iss_ready), 32'h1);

        // simultaneous inc/dec on r4
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd4;
        step();
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd4; bus.wb_wdata = 32'h44;
        bus.raddr1 = 5'd4;
        step();
        idle();
        #1;
        chk("r4_busy", 32'(bus.rbusy1), 32'h1);
        chk("r4_data", bus.rdata1, 32'h44);
        bus.wb_we = 1'b1;
        step();
        idle();
        #1;
        chk("r4_clear", 32'(bus.rbusy1), 32'h0);

        // underflow on r10
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd10; bus.wb_wdata = 32'hA5;
        bus.raddr2 = 5'd10;
        #1;
        chk("r10_byp", bus.rdata2, 32'hA5);
        chk("r10_busy0", 32'(bus.rbusy2), 32'h0);
        step();
        idle();
        #1;
        chk("r10_sto", bus.rdata2, 32'hA5);
        chk("r10_busy1", 32'(bus.rbusy2), 32'h0);

        // flush
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd2;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd6; bus.wb_wdata = 32'h66;
        step();
        bus.wb_we = 1'b0; bus.iss_waddr = 5'd6;
        step();
        idle();
        bus.raddr1 = 5'd2; bus.raddr2 = 5'd6;
        #1;
        chk("fl_pre1", 32'(bus.rbusy1), 32'h1);
        chk("fl_pre2", 32'(bus.rbusy2), 32'h1);
        bus.flush = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd2;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd2; bus.wb_wdata = 32'h22;
        step();
        idle();
        #1;
        chk("fl_busy1", 32'(bus.rbusy1), 32'h0);
        chk("fl_busy2", 32'(bus.rbusy2), 32'h0);
        chk("fl_data1", bus.rdata1, 32'h22);
        chk("fl_data2", bus.rdata2, 32'h66);

        // reset mid-operation
        bus.iss_valid = 1'b1; bus.iss_waddr = 5'd2;
        step();
        idle();
        #1;
        chk("mr_pre", 32'(bus.rbusy1), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mr_data1", bus.rdata1, 32'h0);
        chk("mr_data2", bus.rdata2, 32'h0);
        chk("mr_busy1", 32'(bus.rbusy1), 32'h0);
        chk("mr_busy2", 32'(bus.rbusy2), 32'h0);
        bus.raddr1 = 5'd7;
        #1;
        chk("mr_r7", bus.rdata1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
